wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//   Shares the single register-file write port between two requesters: the core's writeback path
//   (primary; result already selected from ALU, memory data or PC+4) and a long-latency unit such as
//   mul/div (secondary; valid/ready). Secondary results wait in a small FIFO. Primary has priority.
//   A starvation counter forces a secondary grant and stalls the core for one cycle when needed.
// PARAMETERS
//   XLEN        32  data width of every write-port payload
//   DEPTH       2   secondary FIFO entries; power of 2, >=2
//   STARVE_MAX  4   cycles a FIFO head may be passed over before a forced grant; >=1
// PORTS
//   clk        in   1     system clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   p_valid    in   1     primary write request this cycle
//   p_rd       in   5     primary destination register
//   p_data     in   XLEN  primary writeback data
//   p_stall    out  1     primary not granted this cycle; the core must hold its request
//   s_valid    in   1     secondary result valid
//   s_ready    out  1     FIFO can accept (= !full)
//   s_rd       in   5     secondary destination register
//   s_data     in   XLEN  secondary result data
//   s_pending  out  1     FIFO non-empty (used by the core scoreboard)
//   rf_we      out  1     register-file write enable
//   rf_rd      out  5     register-file write address
//   rf_wdata   out  XLEN  register-file write data
// BEHAVIOUR
//   - Reset (rst_n=0, async): FIFO empty, starve_cnt=0, state=NORMAL. While rst_n=0 every output is 0,
//     s_ready included. After release, s_ready=1 and the other outputs are 0 until a request.
//   - Secondary push happens on s_valid&&s_ready. There is no pass-through: data written in cycle N is
//     first eligible for grant in cycle N+1. When full, s_ready=0 even if a pop occurs in the same cycle.
//   - Push and pop may occur in the same cycle when the FIFO is non-empty and not full.
//   - Grant (combinational, same cycle as the request):
//       state NORMAL: grant primary if p_valid; else grant FIFO head if non-empty.
//       state FORCE : grant FIFO head; p_stall=p_valid.
//     p_stall=p_valid && primary not granted. rf_* carry the granted payload; rf_we=0 if nothing is granted.
//   - rd==0: the grant is consumed (FIFO pops / primary not stalled) but rf_we=0.
//   - Starvation: starve_cnt increments on each cycle the FIFO is non-empty and the head is not granted.
//     It clears on a head grant or when the FIFO is empty. When it reaches STARVE_MAX, the next state
//     is FORCE. FORCE lasts exactly one cycle, grants the head, then returns to NORMAL with starve_cnt=0.
//   - FIFO order is strict FIFO. Pointers wrap modulo DEPTH. A count of log2(DEPTH)+1 bits separates
//     full from empty.
//   - Reset mid-operation discards all buffered entries; no partial write is issued.
// CONFIGURATION
//   WB_ARB_PERF_EN defined: adds outputs perf_stall_cnt[31:0] and perf_full_cnt[31:0].
//     perf_stall_cnt counts cycles with p_stall=1; perf_full_cnt counts cycles with s_valid&&!s_ready.
//     Both saturate at 2^32-1 and reset to 0.
//   WB_ARB_PERF_EN undefined: the ports and counters are absent; function is otherwise identical.
// STRUCTURE
//   wb_arb_pkg: typedef rf_wr_t {logic [4:0] rd; logic [XLEN-1:0] data;},
//     enum arb_state_e {NORMAL, FORCE}, localparam REG_ZERO=5'd0.
//   Sub-module wb_skid_fifo (DEPTH x rf_wr_t, push/pop/full/empty/head) instantiated once.
//   The arbiter FSM, starve counter and perf counters stay in the top module.
// TESTING
//   1 Reset: assert rst_n=0 during an s_valid push -> FIFO empty, rf_we=0, s_ready=0; release -> s_ready=1.
//   2 Primary only: p_valid=1, p_rd=5, p_data=0x0000_1234 -> same cycle rf_we=1, rf_rd=5,
//     rf_wdata=0x1234, p_stall=0.
//   3 Secondary only: s_valid=1, s_rd=7, s_data=0xDEAD_BEEF accepted in cycle N -> rf write of rd 7 in
//     cycle N+1; s_pending=0 in N+2.
//   4 Starvation: FIFO head rd=3 with p_valid held high -> primary granted for 4 cycles, then in the
//     5th cycle p_stall=1 and rf_rd=3; primary granted again in the 6th cycle.
//   5 Full: push 2 entries while primary is busy -> s_ready=0 and a third s_valid is held; after one pop,
//     s_ready=1 the next cycle and the third entry is accepted in order.
//   6 x0: p_valid with p_rd=0 -> rf_we=0, p_stall=0. A FIFO entry with rd=0 pops with rf_we=0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback port arbiter: write-port payload, arbiter state, x0 constant.
// XLEN here sets the payload width for the whole block.
package wb_arb_pkg;

    localparam int XLEN = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } rf_wr_t;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_skid_fifo.sv
// Small FIFO buffering secondary write-port results.
// The head is read straight from storage; a push and its first grant never share a cycle.
module wb_skid_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  rf_wr_t wr,
    output rf_wr_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    rf_wr_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    // Storage carries no reset: entries are meaningless once the pointers clear.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_reg == AW'(gi))) begin
                mem[gi] <= wr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between core writeback (priority) and a buffered
// long-latency unit, with starvation-forced grants. Define WB_ARB_PERF_EN for perf counters.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            p_valid,
    input  logic [4:0]      p_rd,
    input  logic [XLEN-1:0] p_data,
    output logic            p_stall,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [4:0]      s_rd,
    input  logic [XLEN-1:0] s_data,
    output logic            s_pending,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_full_cnt
`endif
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_state_e    state_reg, state_next;
    logic [CW-1:0] starve_cnt_reg, starve_cnt_next;

    rf_wr_t s_entry;
    rf_wr_t p_entry;
    rf_wr_t fifo_head;
    rf_wr_t sel;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_push;
    logic   grant_p;
    logic   grant_s;

    assign s_entry   = '{rd: s_rd, data: s_data};
    assign p_entry   = '{rd: p_rd, data: p_data};

    // Outputs are gated by rst_n so they read 0 for the whole reset assertion.
    assign s_ready   = rst_n && !fifo_full;
    assign fifo_push = s_valid && s_ready;
    assign s_pending = rst_n && !fifo_empty;

    wb_skid_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (grant_s),
        .wr    (s_entry),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= NORMAL;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    always_comb begin
        grant_p         = 1'b0;
        grant_s         = 1'b0;
        state_next      = NORMAL;
        starve_cnt_next = starve_cnt_reg;

        case (state_reg)
            NORMAL: begin
                if (p_valid) begin
                    grant_p = 1'b1;
                end else if (!fifo_empty) begin
                    grant_s = 1'b1;
                end
            end
            FORCE: begin
                grant_s = !fifo_empty;
            end
            default: begin
                grant_p = p_valid;
            end
        endcase

        if (fifo_empty || grant_s) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg < STARVE_LIM) begin
            starve_cnt_next = starve_cnt_reg + CW'(1);
        end

        // FORCE is a single cycle: its head grant clears the counter, so it never re-arms itself.
        if ((state_reg == NORMAL) && (starve_cnt_next == STARVE_LIM)) begin
            state_next = FORCE;
        end
    end

    always_comb begin
        sel = '0;
        if (grant_s) begin
            sel = fifo_head;
        end else if (grant_p) begin
            sel = p_entry;
        end
    end

    assign p_stall  = rst_n && p_valid && !grant_p;
    assign rf_we    = rst_n && (grant_p || grant_s) && (sel.rd != REG_ZERO);
    assign rf_rd    = rst_n ? sel.rd : 5'd0;
    assign rf_wdata = rst_n ? sel.data : '0;

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_full_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_reg <= '0;
            perf_full_reg  <= '0;
        end else begin
            if (p_stall && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
            if (s_valid && !s_ready && (perf_full_reg != '1)) begin
                perf_full_reg <= perf_full_reg + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_reg;
    assign perf_full_cnt  = perf_full_reg;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, primary, secondary, starvation, full FIFO, x0, mid-run reset.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p_valid;
    logic [4:0]  p_rd;
    logic [31:0] p_data;
    logic        p_stall;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    logic        s_pending;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_full_cnt;
`endif

    int checks_cnt;
    int fail_cnt;

    wb_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p_valid   (p_valid),
        .p_rd      (p_rd),
        .p_data    (p_data),
        .p_stall   (p_stall),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_rd      (s_rd),
        .s_data    (s_data),
        .s_pending (s_pending),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_full_cnt  (perf_full_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic drive_p(input logic v, input logic [4:0] rd, input logic [31:0] d);
        p_valid = v;
        p_rd    = rd;
        p_data  = d;
    endtask

    task automatic drive_s(input logic v, input logic [4:0] rd, input logic [31:0] d);
        s_valid = v;
        s_rd    = rd;
        s_data  = d;
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic grant(input string tag, input logic we, input logic [4:0] rd,
                         input logic [31:0] d, input logic stall);
        chk({tag, ".rf_we"}, 32'(rf_we), 32'(we));
        chk({tag, ".rf_rd"}, 32'(rf_rd), 32'(rd));
        chk({tag, ".rf_wdata"}, rf_wdata, d);
        chk({tag, ".p_stall"}, 32'(p_stall), 32'(stall));
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst_n      = 1'b0;
        drive_p(1'b0, 5'd0, 32'd0);
        drive_s(1'b1, 5'd9, 32'h0000_0099);

        // Reset held while a secondary push is offered
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.s_ready", 32'(s_ready), 32'd0);
        chk("rst.rf_we", 32'(rf_we), 32'd0);
        chk("rst.s_pending", 32'(s_pending), 32'd0);
        s_valid = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        chk("rel.s_ready", 32'(s_ready), 32'd1);
        chk("rel.s_pending", 32'(s_pending), 32'd0);
        grant("rel", 1'b0, 5'd0, 32'd0, 1'b0);
        next_cycle();

        // Primary only
        drive_p(1'b1, 5'd5, 32'h0000_1234);
        @(negedge clk);
        grant("prim", 1'b1, 5'd5, 32'h0000_1234, 1'b0);
        next_cycle();
        drive_p(1'b0, 5'd0, 32'd0);

        // Secondary only: accepted in N, written in N+1, gone in N+2
        drive_s(1'b1, 5'd7, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sec.N.s_ready", 32'(s_ready), 32'd1);
        chk("sec.N.rf_we", 32'(rf_we), 32'd0);
        next_cycle();
        drive_s(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        grant("sec.N1", 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
        chk("sec.N1.s_pending", 32'(s_pending), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("sec.N2.s_pending", 32'(s_pending), 32'd0);
        chk("sec.N2.rf_we", 32'(rf_we), 32'd0);
        next_cycle();

        // Starvation: head rd=3 passed over 4 cycles, forced in the 5th
        drive_p(1'b1, 5'd1, 32'h0000_0100);
        drive_s(1'b1, 5'd3, 32'h0000_0033);
        @(negedge clk);
        grant("stv.push", 1'b1, 5'd1, 32'h0000_0100, 1'b0);
        next_cycle();
        drive_s(1'b0, 5'd0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            grant($sformatf("stv.c%0d", i), 1'b1, 5'd1, 32'h0000_0100, 1'b0);
            next_cycle();
        end
        @(negedge clk);
        grant("stv.c5", 1'b1, 5'd3, 32'h0000_0033, 1'b1);
        next_cycle();
        @(negedge clk);
        grant("stv.c6", 1'b1, 5'd1, 32'h0000_0100, 1'b0);
        chk("stv.c6.s_pending", 32'(s_pending), 32'd0);
        next_cycle();

        // Full FIFO: two entries buffered behind a busy primary, third held
        drive_p(1'b1, 5'd2, 32'h0000_0222);
        drive_s(1'b1, 5'd10, 32'h0000_000A);
        @(negedge clk);
        chk("full.c1.s_ready", 32'(s_ready), 32'd1);
        next_cycle();
        drive_s(1'b1, 5'd11, 32'h0000_000B);
        @(negedge clk);
        chk("full.c2.s_ready", 32'(s_ready), 32'd1);
        next_cycle();
        drive_s(1'b1, 5'd12, 32'h0000_000C);
        @(negedge clk);
        chk("full.c3.s_ready", 32'(s_ready), 32'd0);
        grant("full.c3", 1'b1, 5'd2, 32'h0000_0222, 1'b0);
        next_cycle();
        drive_p(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("full.c4.s_ready", 32'(s_ready), 32'd0);
        grant("full.c4", 1'b1, 5'd10, 32'h0000_000A, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("full.c5.s_ready", 32'(s_ready), 32'd1);
        grant("full.c5", 1'b1, 5'd11, 32'h0000_000B, 1'b0);
        next_cycle();
        drive_s(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        grant("full.c6", 1'b1, 5'd12, 32'h0000_000C, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("full.c7.s_pending", 32'(s_pending), 32'd0);
        next_cycle();

        // x0 writes are consumed without enabling the write port
        drive_p(1'b1, 5'd0, 32'h0000_5555);
        @(negedge clk);
        chk("x0p.rf_we", 32'(rf_we), 32'd0);
        chk("x0p.p_stall", 32'(p_stall), 32'd0);
        next_cycle();
        drive_p(1'b0, 5'd0, 32'd0);
        drive_s(1'b1, 5'd0, 32'h0000_6666);
        next_cycle();
        drive_s(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("x0s.rf_we", 32'(rf_we), 32'd0);
        chk("x0s.s_pending", 32'(s_pending), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("x0s.popped", 32'(s_pending), 32'd0);
        next_cycle();

        // Reset mid-operation discards a buffered entry
        drive_s(1'b1, 5'd4, 32'h0000_0444);
        next_cycle();
        drive_s(1'b0, 5'd0, 32'd0);
        drive_p(1'b1, 5'd6, 32'h0000_0666);
        @(negedge clk);
        chk("mid.s_pending", 32'(s_pending), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid.rst.s_pending", 32'(s_pending), 32'd0);
        chk("mid.rst.s_ready", 32'(s_ready), 32'd0);
        grant("mid.rst", 1'b0, 5'd0, 32'd0, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid.rel.s_pending", 32'(s_pending), 32'd0);
        grant("mid.rel", 1'b1, 5'd6, 32'h0000_0666, 1'b0);
        next_cycle();
        drive_p(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("mid.idle.rf_we", 32'(rf_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
